// File: rtl/vga_dbg_pkg.sv
// vga_dbg_pkg: shared types and sizing helpers for the VGA debug snapshot engine.
package vga_dbg_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, READY} state_e;
  localparam bit BLANK_BIT = 1'b0;
  function automatic int num_pages(input int num_ch, input int rows, input int words);
    return (num_ch + rows * words - 1) / (rows * words);
  endfunction
  function automatic int page_w(input int np);
    return np > 1 ? $clog2(np) : 1;
  endfunction
endpackage

// File: rtl/vga_dbg_bank_ram.sv
// vga_dbg_bank_ram: two-bank {changed, word} store; back-bank write, registered
// renderer read and combinational compare read of the front bank.
module vga_dbg_bank_ram
  import vga_dbg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IW     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              front_sel,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [DATA_W:0]   wdata,
  input  logic              rd_en,
  input  logic [IW-1:0]     raddr,
  output logic [DATA_W:0]   rdata,
  input  logic [IW-1:0]     caddr,
  output logic [DATA_W-1:0] cdata
);
  logic [DATA_W:0] mem [2**(IW+1)];
  logic [DATA_W:0] rdata_d, rdata_q;
  always_ff @(posedge clk)
    if (we) mem[{~front_sel, waddr}] <= wdata;
  assign cdata = mem[{front_sel, caddr}][DATA_W-1:0];
  always_comb rdata_d = rd_en ? mem[{front_sel, raddr}] : {(DATA_W+1){BLANK_BIT}};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else rdata_q <= rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/vga_debug_snapshot.sv
// vga_debug_snapshot: scans debug words into a back bank and publishes it on a
// frame boundary, with freeze/single-shot capture, paging and change flags.
module vga_debug_snapshot
  import vga_dbg_pkg::*;
#(
  parameter int NUM_CH        = 64,
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 7,
  parameter int SETTLE        = 1,
  parameter int ROWS_PER_PAGE = 20,
  parameter int WORDS_PER_ROW = 2,
  localparam int NUM_PAGES    = num_pages(NUM_CH, ROWS_PER_PAGE, WORDS_PER_ROW),
  localparam int PW           = page_w(NUM_PAGES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              freeze,
  input  logic              single,
  input  logic              page_inc,
  input  logic              page_dec,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_changed,
  output logic [PW-1:0]     page,
  output logic [ADDR_W-1:0] page_base,
  output logic              scan_busy,
  output logic [15:0]       snap_count
);
  localparam int IW = $clog2(NUM_CH);
  localparam int PAGE_WORDS = ROWS_PER_PAGE * WORDS_PER_ROW;
  localparam logic [ADDR_W-1:0] LAST_CH = ADDR_W'(NUM_CH - 1);
  localparam logic [2:0] SETTLE_V = 3'(SETTLE);
  localparam logic [PW-1:0] LAST_PG = PW'(NUM_PAGES - 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] ch_q, ch_d, page_base_q, page_base_d;
  logic [2:0] settle_q, settle_d;
  logic front_sel_q, front_sel_d, front_valid_q, front_valid_d;
  logic single_pend_q, single_pend_d;
  logic [15:0] snap_count_q, snap_count_d;
  logic [PW-1:0] page_q, page_d;
  logic go, flip, we, changed;
  logic [DATA_W:0] rdata;
  logic [DATA_W-1:0] cdata;
  always_comb begin
    go = !freeze || single_pend_q;
    flip = (state_q == READY) && frame_start && go;
    state_d = state_q;
    ch_d = ch_q;
    settle_d = settle_q;
    we = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        state_d = SCAN;
        ch_d = '0;
        settle_d = '0;
      end
      SCAN: if (settle_q == SETTLE_V) begin
        we = 1'b1;
        settle_d = '0;
        ch_d = ch_q + 1'b1;
        if (ch_q == LAST_CH) state_d = READY;
      end else settle_d = settle_q + 1'b1;
      READY: if (flip) begin
        state_d = freeze ? IDLE : SCAN;
        ch_d = '0;
        settle_d = '0;
      end
      default: state_d = IDLE;
    endcase
    changed = (dbg_data != cdata) || !front_valid_q;
    front_sel_d = front_sel_q ^ flip;
    front_valid_d = front_valid_q | flip;
    snap_count_d = flip ? snap_count_q + 16'd1 : snap_count_q;
    single_pend_d = flip ? 1'b0 : (single_pend_q | single);
  end
  // Simultaneous inc and dec cancel out.
  always_comb begin
    page_d = page_q;
    if (page_inc && !page_dec) page_d = (page_q == LAST_PG) ? '0 : page_q + 1'b1;
    if (page_dec && !page_inc) page_d = (page_q == '0) ? LAST_PG : page_q - 1'b1;
    page_base_d = ADDR_W'(int'(page_d) * PAGE_WORDS);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q <= '0;
      settle_q <= '0;
      front_sel_q <= 1'b0;
      front_valid_q <= 1'b0;
      single_pend_q <= 1'b0;
      snap_count_q <= '0;
      page_q <= '0;
      page_base_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      settle_q <= settle_d;
      front_sel_q <= front_sel_d;
      front_valid_q <= front_valid_d;
      single_pend_q <= single_pend_d;
      snap_count_q <= snap_count_d;
      page_q <= page_d;
      page_base_q <= page_base_d;
    end
  vga_dbg_bank_ram #(.DATA_W(DATA_W), .IW(IW)) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .front_sel(front_sel_q),
    .we       (we),
    .waddr    (ch_q[IW-1:0]),
    .wdata    ({changed, dbg_data}),
    .rd_en    (front_valid_q && (rd_idx <= LAST_CH)),
    .raddr    (rd_idx[IW-1:0]),
    .rdata    (rdata),
    .caddr    (ch_q[IW-1:0]),
    .cdata    (cdata)
  );
  assign dbg_addr = (state_q == SCAN) ? ch_q : '0;
  assign scan_busy = state_q == SCAN;
  assign rd_data = rdata[DATA_W-1:0];
  assign rd_changed = rdata[DATA_W];
  assign page = page_q;
  assign page_base = page_base_q;
  assign snap_count = snap_count_q;
endmodule

// File: doc/vga_debug_snapshot.md
Name: vga_debug_snapshot

Overview:
Frame-coherent capture engine for the VGA debug display. It scans NUM_CH debug words through the shared debug address/data bus and latches them into a double-buffered snapshot. The front bank is published only on a frame boundary, so the text renderer never shows a half-updated screen. It adds freeze and single-shot capture, wrap-around paging, and per-word "changed since last snapshot" flags used for highlight colouring.

Parameters:
NUM_CH, 64, number of debug words scanned (>=2)
DATA_W, 32, debug word width
ADDR_W, 7, dbg_addr width; 2**ADDR_W >= NUM_CH
SETTLE, 1, wait cycles after dbg_addr changes before sampling dbg_data (0..7)
ROWS_PER_PAGE, 20, text rows per page
WORDS_PER_ROW, 2, debug words per text row

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank
freeze  in  1  level; 1 = hold the displayed snapshot
single  in  1  one-cycle pulse; request one capture while frozen
page_inc  in  1  one-cycle pulse; next page
page_dec  in  1  one-cycle pulse; previous page
dbg_addr  out  ADDR_W  debug word select driven to the CPU/datapath
dbg_data  in  DATA_W  debug word returned for dbg_addr
rd_idx  in  ADDR_W  renderer read index
rd_data  out  DATA_W  front-bank word at rd_idx, 1-cycle latency
rd_changed  out  1  front-bank changed flag at rd_idx, 1-cycle latency
page  out  clog2(NUM_PAGES)  current page
page_base  out  ADDR_W  page*ROWS_PER_PAGE*WORDS_PER_ROW
scan_busy  out  1  1 while in SCAN
snap_count  out  16  number of bank flips, wraps at 0xFFFF->0

Behaviour:
- Reset values: dbg_addr=0, rd_data=0, rd_changed=0, page=0, page_base=0, scan_busy=0, snap_count=0. Internal: front bank=0, front_valid=0, single_pend=0, FSM=IDLE.
- FSM states IDLE, SCAN, READY:
  - IDLE->SCAN when freeze=0 or single_pend=1. Channel counter ch=0.
  - SCAN: dbg_addr=ch. Wait SETTLE cycles, then on the next cycle write dbg_data into the back bank at ch. In the same cycle, write changed = (dbg_data != front[ch]) || !front_valid. ch increments. After ch=NUM_CH-1 is written, go to READY. A scan therefore takes NUM_CH*(SETTLE+1) cycles.
  - READY: on frame_start with (freeze=0 or single_pend=1), flip front/back, set front_valid=1, increment snap_count, clear single_pend. Next state is SCAN if freeze=0, else IDLE. If the flip is blocked, stay in READY; the back bank is retained.
- frame_start in IDLE or SCAN is ignored; the flip waits for the next frame_start after READY.
- dbg_addr holds 0 outside SCAN.
- single sets single_pend, and is ignored while single_pend=1. If freeze=0, single only sets the flag, which is cleared at the next flip.
- Freeze asserted mid-scan: the scan completes and the FSM waits in READY. Deassert: the flip occurs at the next frame_start.
- Read port: rd_data and rd_changed are registered from the front bank one cycle after rd_idx. They read 0 when rd_idx>=NUM_CH or front_valid=0.
- Paging: NUM_PAGES = ceil(NUM_CH/(ROWS_PER_PAGE*WORDS_PER_ROW)).
  - page_inc at the last page wraps to 0; page_dec at 0 wraps to NUM_PAGES-1.
  - page_inc and page_dec in the same cycle: no change.
  - page_base is registered with page, with no lag.
- Reset mid-scan aborts everything; the first display after reset requires a full scan plus a frame_start.

Decomposition:
- Package vga_dbg_pkg holds:
  - the state enum (IDLE/SCAN/READY);
  - the NUM_PAGES and page-width calculation function;
  - the blank-word constant 0.
- Sub-module vga_dbg_bank_ram: two banks of NUM_CH x (DATA_W+1) bits, storing word plus changed bit. It has:
  - one write port to the back bank;
  - one synchronous read port on the front bank for the renderer;
  - one asynchronous or compare read of the front bank at ch.
  The bank select is an input.

Test Plan:
- NUM_CH=8, SETTLE=1, freeze=0, dbg_data=0x100+addr → dbg_addr steps 0..7 with each value held 2 cycles. The first frame_start after 16 cycles flips the banks: snap_count=1, and rd_idx=3 gives rd_data=0x103 and rd_changed=1 one cycle later.
- Second scan with dbg_data=0x100+addr except addr 5 = 0xDEAD → after the flip, rd_changed is 1 only at idx 5, and rd_data[5]=0xDEAD.
- freeze=1 set mid-scan, then two frame_starts → snap_count stays unchanged and rd_data keeps its old values. A single pulse followed by frame_start → exactly one flip (snap_count+1), then IDLE with dbg_addr=0.
- frame_start arriving at scan cycle 10 of 16 → no flip. The flip occurs at the next frame_start after READY.
- NUM_CH=64, 20x2 → NUM_PAGES=2. page_inc twice gives page 1→0 with page_base 40→0. page_dec at 0 gives 1. page_inc and page_dec together → no change.
- rst_n low during SCAN at ch=4 → all outputs return to their reset values asynchronously, rd_data=0 for any idx, and scan restarts from ch=0 after release.
